serial_adder_seq: RTL
=====================

Name: serial_adder_seq

Overview:
- Bit-serial adder built around the existing single-bit full-adder cell, plus a carry flip-flop, operand shift registers and a small controller.
- Computes {cout,sum} = a + b + cin over WIDTH cycles, LSB first.
- Sits alongside the Vedic multiplier datapath as a low-area partial-product accumulator stage.
- Consumes the full-adder cell's sum/cout each cycle and presents a registered WIDTH-bit result with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse: sum/cout just updated
- sum  output  WIDTH  registered result, low WIDTH bits
- cout  output  1  registered final carry-out

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter all 0.
  - Any operation in flight is aborted; no done pulse follows.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - start=1 at edge E0: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN, each edge Ek (k=1..WIDTH):
  - Full-adder cell inputs: a_sr[0], b_sr[0], carry.
  - acc_sr shifts right with the cell's sum bit entering the MSB.
  - a_sr and b_sr shift right.
  - carry<=cell cout; cnt<=cnt+1.
- RUN completion (processing edge where cnt==WIDTH-1, i.e. E_WIDTH):
  - sum<= final accumulated word, including this cycle's bit.
  - cout<= this cycle's cell cout.
  - done<=1; state<=IDLE.
- busy:
  - Registered; 1 from E0 through E_WIDTH, 0 from E_WIDTH onward.
  - busy falls in the same cycle done rises.
- done: exactly one cycle high, deasserted on the next edge unless a new completion occurs.
- Latency: result valid and done high WIDTH edges after the start edge (8 cycles for WIDTH=8).
- Throughput: one addition per WIDTH+1 cycles.
  - start may be high in the done cycle (state is IDLE); it is accepted, giving back-to-back operation.
- start while busy=1: ignored. No effect on the operation in progress or on the captured operands.
- a, b, cin may change freely after the start edge; only captured values are used.
- sum and cout hold their last values until the next completion. They are never updated with partial results.
- Arithmetic: {cout,sum} equals the exact (WIDTH+1)-bit sum of a+b+cin. Overflow is reported only via cout.
- cnt width: clog2(WIDTH); it wraps to 0 on return to IDLE.

Test Plan:
- Reset, then WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle -> busy high 8 cycles; done pulses 8 edges after start; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- During a run of 0x12+0x34, pulse start with a=0xAA, b=0x55 at cycle 3 -> ignored; result sum=0x46, cout=0; exactly one done pulse.
- Hold start high continuously with new operands presented each done cycle (0x01+0x02, then 0x80+0x80) -> results 0x03/cout0 then 0x00/cout1; done pulses spaced 9 cycles apart.
- Assert rst_n low at cycle 4 of a run of 0xF0+0x0F -> busy, done, sum, cout drop to 0 immediately (asynchronously); no done after release; a following 0x01+0x01 gives 0x02.
- 1000 random a, b, cin with random start gaps, compared against a reference adder -> every {cout,sum} matches; done count equals accepted start count.

Source files
------------

// File: rtl/serial_adder_seq_if.sv
// ---------------------------------------------------------------------------
// serial_adder_seq_if
// Request/result bundle for the bit-serial adder.
//   start      : request to begin an addition (sampled only when idle)
//   a, b, cin  : operands, captured on the accepted start edge
//   busy       : addition in progress
//   done       : one-cycle pulse, sum/cout just updated
//   sum, cout  : registered result and final carry
// master = requester side, slave = adder side.
// ---------------------------------------------------------------------------
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface : serial_adder_seq_if

// File: rtl/serial_adder_seq.sv
// ---------------------------------------------------------------------------
// serial_adder_seq
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per cycle, LSB first,
// using a single full-adder cell and a carry flop. A start accepted while
// idle captures the operands; the result appears WIDTH edges later together
// with a one-cycle done pulse. Starts arriving while busy are ignored.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any addition in flight
//   bus   : serial_adder_seq_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// WIDTH must match the WIDTH of the connected interface (legal 2..32).
// ---------------------------------------------------------------------------

// Single-bit full-adder cell.
module serial_adder_seq_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule : serial_adder_seq_fa

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_seq_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] acc_sr_q, acc_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;

    // The cell always sees the current LSBs; its outputs are only consumed in RUN.
    serial_adder_seq_fa u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_sum),
        .co (fa_cout)
    );

    // Accumulator after this cycle's bit enters at the MSB; after WIDTH shifts
    // bit 0 of the result has reached position 0.
    assign acc_next = {fa_sum, acc_sr_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this
        // block leaves a signal unassigned, which would infer a latch.
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        acc_sr_d = acc_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    acc_sr_d = '0;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end

            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                acc_sr_d = acc_next;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Only the completed word is published; sum/cout never
                    // show partial results.
                    sum_d   = acc_next;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            acc_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            acc_sr_q <= acc_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule : serial_adder_seq
